// File: rtl/gbfwei_rd_ctrl.sv
// gbfwei_rd_ctrl: read-side controller for the weight global buffer (GBFWEI).
// Streams a contiguous block of words out of the single-port SRAM, absorbs the
// 1-cycle read latency in a 2-entry skid FIFO and presents the words on a
// valid/ready interface. Reads yield to the write side whenever wr_busy is high.
// Optional build macro: GBFWEI_RD_STALL_CNT_EN adds the 16-bit stall_cnt output.
module gbfwei_rd_ctrl #(
   parameter int SRAM_DEPTH_BIT = 6,
   parameter int SRAM_WIDTH     = 28,
   parameter int CNT_BIT        = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [SRAM_DEPTH_BIT-1:0] base_addr,
   input  logic [CNT_BIT-1:0]        num_words,
   input  logic                      wr_busy,
   output logic                      read_en,
   output logic [SRAM_DEPTH_BIT-1:0] addr_r,
   input  logic [SRAM_WIDTH-1:0]     data_out,
   output logic [SRAM_WIDTH-1:0]     dout,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic                      busy,
   output logic                      done
`ifdef GBFWEI_RD_STALL_CNT_EN
   ,output logic [15:0]              stall_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [CNT_BIT-1:0]    remaining;
   logic                  inflight;
   logic                  zero_done;
   logic [SRAM_WIDTH-1:0] fifo_mem [2];
   logic                  rd_ptr, wr_ptr;
   logic [1:0]            occ;
   logic [2:0]            fill_after_pop;
   logic                  push, pop, issue, start_acc, drain_done;

   // FIFO handshake and issue qualification
   assign push           = inflight;
   assign pop            = dout_valid & dout_ready;
   assign dout_valid     = (occ != 2'd0);
   assign dout           = fifo_mem[rd_ptr];
   assign fill_after_pop = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign start_acc      = (state == IDLE) && start && !zero_done;
   assign issue          = (state == READ) && (remaining != '0) && !wr_busy
                           && (fill_after_pop < 3'd2);
   assign drain_done     = (state == DRAIN) && !inflight && (occ == {1'b0, pop});

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_acc && (num_words != '0)) state_nxt = READ;
         READ:    if (issue && (remaining == CNT_BIT'(1))) state_nxt = DRAIN;
         DRAIN:   if (drain_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: read_en is decoded from registered state plus same-cycle
   // wr_busy/pop so a read never collides with a write and the FIFO never overflows
   always_comb begin
      read_en = issue;
      busy    = (state == READ) || (state == DRAIN);
      done    = zero_done || drain_done;
   end

   // Address/count, in-flight tracking and skid FIFO storage
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r    <= '0;
         remaining <= '0;
         inflight  <= 1'b0;
         zero_done <= 1'b0;
         occ       <= 2'd0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
      end else begin
         inflight  <= issue;
         zero_done <= start_acc && (num_words == '0);
         if (start_acc) begin
            addr_r    <= base_addr;
            remaining <= num_words;
         end else if (issue) begin
            addr_r    <= addr_r + 1'b1;
            remaining <= remaining - 1'b1;
         end
         if (push) begin
            fifo_mem[wr_ptr] <= data_out;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

`ifdef GBFWEI_RD_STALL_CNT_EN
   // Saturating count of READ cycles that wanted to issue but could not
   always_ff @(posedge clk) begin
      if (rst || start_acc)
         stall_cnt <= '0;
      else if ((state == READ) && (remaining != '0) && !issue && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule
